// File: rtl/sect233r1_pt_check_if.sv
// sect233r1_pt_check_if
//   Bundles the request/result signals of the sect233r1 point validator.
//   master : requester side; drives clr, start, x, y and observes the result.
//   slave  : validator side; samples the request and drives busy/done/valid/inf.
//   Ports
//     clr    abort the running check and return to idle
//     start  check request; x, y are captured when it is accepted
//     x, y   affine point coordinates, M bits each
//     busy   check in progress
//     done   one-cycle pulse, result valid
//     valid  1 = point lies on the curve
//     inf    1 = point at infinity (0,0) was reported
interface sect233r1_pt_check_if #(
  parameter int M = 233
);
  logic         clr;
  logic         start;
  logic [M-1:0] x;
  logic [M-1:0] y;
  logic         busy;
  logic         done;
  logic         valid;
  logic         inf;

  modport master (output clr, start, x, y, input busy, done, valid, inf);
  modport slave  (input clr, start, x, y, output busy, done, valid, inf);
endinterface

// File: rtl/sect233r1_pt_check.sv
// sect233r1_pt_check
//   Checks that a received affine point (x,y) satisfies
//   y^2 + x*y = x^3 + x^2 + b over GF(2^M), f(x) = x^M + FX.
//   Four products (x*x, y*y, x*y, x^2*x) run through one digit-serial
//   multiplier, NSEG cycles each, followed by a one-cycle compare.
//   Ports
//     clk    system clock
//     rst_n  synchronous reset, active low
//     bus    sect233r1_pt_check_if.slave (clr, start, x, y, busy, done, valid, inf)
//   Build option
//     SECT_PT_CHECK_INF_EN : (0,0) at accept bypasses the products and is
//     reported as valid point at infinity two cycles after accept.
//     Without it (0,0) is evaluated like any other point and inf is tied 0.
//
//   state  | meaning
//   IDLE   | waiting for start
//   MUL    | running product op (0..3), digit segment seg (0..NSEG-1)
//   CMP    | compare lhs against rhs, register valid, pulse done
module sect233r1_pt_check #(
  parameter int           M     = 233,
  parameter logic [M-1:0] FX    = 233'h4000000000000000001,
  parameter logic [M-1:0] B     = 233'h66647ede6c332c7f8c0923bb58213b333b20e9ce4281fe115f7d8f90ad,
  parameter int           DIGIT = 47
) (
  input logic                clk,
  input logic                rst_n,
  sect233r1_pt_check_if.slave bus
);

  localparam int NSEG = (M + DIGIT - 1) / DIGIT;
  localparam int PW   = NSEG * DIGIT;
  localparam int SW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [SW-1:0] SEG_LAST = SW'(NSEG - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_CMP} state_t;

  state_t       state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [SW-1:0] seg_q, seg_d;
  logic [M-1:0] x_q, x_d, y_q, y_d;
  logic [M-1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
  logic [M-1:0] acc_q, acc_d;
  logic         busy_q, busy_d, done_q, done_d, valid_q, valid_d;
`ifdef SECT_PT_CHECK_INF_EN
  logic         inf_q, inf_d;
  logic         pt_zero;
`endif

  logic [M-1:0]     op_a, op_b, prod, lhs, rhs;
  logic [PW-1:0]    bpad;
  logic [DIGIT-1:0] dig;

  // acc*z^DIGIT + a*d, reduced mod f. Folds high bits top-down so any FX works.
  function automatic logic [M-1:0] gf_step(input logic [M-1:0] acc,
                                           input logic [M-1:0] a,
                                           input logic [DIGIT-1:0] d);
    logic [M+DIGIT-1:0] t;
    t = {acc, {DIGIT{1'b0}}};
    for (int i = 0; i < DIGIT; i++) begin
      if (d[i]) t ^= {{DIGIT{1'b0}}, a} << i;
    end
    for (int i = M + DIGIT - 1; i >= M; i--) begin
      if (t[i]) begin
        t[i] = 1'b0;
        t ^= {{DIGIT{1'b0}}, FX} << (i - M);
      end
    end
    return t[M-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    seg_d   = seg_q;
    x_d     = x_q;
    y_d     = y_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    t3_d    = t3_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
`ifdef SECT_PT_CHECK_INF_EN
    inf_d   = inf_q;
    pt_zero = (x_q == '0) && (y_q == '0);
`endif

    case (op_q)
      2'd0:    begin op_a = x_q;  op_b = x_q; end
      2'd1:    begin op_a = y_q;  op_b = y_q; end
      2'd2:    begin op_a = x_q;  op_b = y_q; end
      default: begin op_a = t1_q; op_b = x_q; end
    endcase

    // multiplier digits are taken MSB-first; the top digit is zero-padded
    bpad = {{(PW - M){1'b0}}, op_b};
    dig  = DIGIT'(bpad >> (DIGIT * (NSEG - 1 - int'(seg_q))));
    prod = gf_step(acc_q, op_a, dig);

    lhs = t2_q ^ t3_q;
    rhs = acc_q ^ t1_q ^ B;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d     = bus.x;
          y_d     = bus.y;
          op_d    = 2'd0;
          seg_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          valid_d = 1'b0;
`ifdef SECT_PT_CHECK_INF_EN
          inf_d   = 1'b0;
`endif
          state_d = S_MUL;
        end
      end
      S_MUL: begin
`ifdef SECT_PT_CHECK_INF_EN
        if (pt_zero) begin
          state_d = S_CMP;
        end else
`endif
        if (seg_q == SEG_LAST) begin
          seg_d = '0;
          op_d  = op_q + 2'd1;
          acc_d = '0;
          case (op_q)
            2'd0:    t1_d = prod;
            2'd1:    t2_d = prod;
            2'd2:    t3_d = prod;
            default: begin
              acc_d   = prod;  // t4 stays in the accumulator for the compare
              state_d = S_CMP;
            end
          endcase
        end else begin
          seg_d = seg_q + SW'(1);
          acc_d = prod;
        end
      end
      S_CMP: begin
        valid_d = (lhs == rhs);
`ifdef SECT_PT_CHECK_INF_EN
        if (pt_zero) begin
          valid_d = 1'b1;
          inf_d   = 1'b1;
        end
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.clr) begin
      state_d = S_IDLE;
      op_d    = 2'd0;
      seg_d   = '0;
      x_d     = '0;
      y_d     = '0;
      t1_d    = '0;
      t2_d    = '0;
      t3_d    = '0;
      acc_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      valid_d = 1'b0;
`ifdef SECT_PT_CHECK_INF_EN
      inf_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      seg_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      t3_q    <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef SECT_PT_CHECK_INF_EN
      inf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      seg_q   <= seg_d;
      x_q     <= x_d;
      y_q     <= y_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      t3_q    <= t3_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
`ifdef SECT_PT_CHECK_INF_EN
      inf_q   <= inf_d;
`endif
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.valid = valid_q;
`ifdef SECT_PT_CHECK_INF_EN
  assign bus.inf   = inf_q;
`else
  assign bus.inf   = 1'b0;
`endif

endmodule

// File: tb/tb_sect233r1_pt_check.sv
module tb_sect233r1_pt_check;

  localparam logic [232:0] XG = 233'hfac9dfcbac8313bb2139f1bb755fef65bc391f8b36f8f8eb7371fd558b;
  localparam logic [232:0] YG = 233'h1006a08a41903350678e58528bebf8a0beff867a7ca36716f7e01f81052;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_checks = 0;
  int   done_cnt = 0;
  int   lat, lat2, d0;

  always #5 clk = ~clk;

  sect233r1_pt_check_if #(.M(233)) bus_if ();

  sect233r1_pt_check dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always @(negedge clk) begin
    if (bus_if.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input logic [232:0] xv, input logic [232:0] yv);
    bus_if.x     = xv;
    bus_if.y     = yv;
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
  endtask

  // edges counted after the accepting edge until done is seen; -1 on timeout
  task automatic wait_done(output int l);
    l = -1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (bus_if.done === 1'b1) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    bus_if.clr   = 1'b0;
    bus_if.start = 1'b0;
    bus_if.x     = '0;
    bus_if.y     = '0;
    @(negedge clk);
    step();
    step();
    chk("reset_busy",  int'(bus_if.busy),  0);
    chk("reset_done",  int'(bus_if.done),  0);
    chk("reset_valid", int'(bus_if.valid), 0);
    chk("reset_inf",   int'(bus_if.inf),   0);
    rst_n = 1'b1;
    step();

    // 1: generator point; inputs change right after accept
    issue(XG, YG);
    bus_if.x = ~XG;
    bus_if.y = '0;
    chk("t1_busy", int'(bus_if.busy), 1);
    wait_done(lat);
    chk("t1_latency", lat, 21);
    chk("t1_valid", int'(bus_if.valid), 1);
    chk("t1_inf", int'(bus_if.inf), 0);
    chk("t1_busy_low", int'(bus_if.busy), 0);
    step();
    chk("t1_done_pulse", int'(bus_if.done), 0);
    chk("t1_valid_held", int'(bus_if.valid), 1);

    // 2: y flipped in bit 0
    issue(XG, YG ^ 233'd1);
    chk("t2_valid_cleared", int'(bus_if.valid), 0);
    wait_done(lat);
    chk("t2_latency", lat, 21);
    chk("t2_valid", int'(bus_if.valid), 0);
    step();

    // 3: (0,0)
    issue('0, '0);
    wait_done(lat);
`ifdef SECT_PT_CHECK_INF_EN
    chk("t3_latency", lat, 2);
    chk("t3_valid", int'(bus_if.valid), 1);
    chk("t3_inf", int'(bus_if.inf), 1);
`else
    chk("t3_latency", lat, 21);
    chk("t3_valid", int'(bus_if.valid), 0);
    chk("t3_inf", int'(bus_if.inf), 0);
`endif
    step();

    // 4: second start during a check is ignored
    d0 = done_cnt;
    issue(XG, YG);
    repeat (4) step();
    issue('0, '0);
    wait_done(lat);
    chk("t4_latency", lat, 16);
    chk("t4_valid", int'(bus_if.valid), 1);
    chk("t4_inf", int'(bus_if.inf), 0);
    repeat (30) step();
    chk("t4_done_count", done_cnt - d0, 1);

    // 5: clr at cycle 10
    issue(XG, YG);
    repeat (8) step();
    bus_if.clr = 1'b1;
    step();
    bus_if.clr = 1'b0;
    chk("t5_busy", int'(bus_if.busy), 0);
    chk("t5_valid", int'(bus_if.valid), 0);
    d0 = done_cnt;
    repeat (20) step();
    chk("t5_no_done", done_cnt - d0, 0);
    issue(XG, YG);
    wait_done(lat);
    chk("t5_latency", lat, 21);
    chk("t5_valid_after", int'(bus_if.valid), 1);
    step();

    // 6: reset mid-check, then back-to-back starts on the done cycle
    issue(XG, YG);
    repeat (8) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_rst_busy",  int'(bus_if.busy),  0);
    chk("t6_rst_done",  int'(bus_if.done),  0);
    chk("t6_rst_valid", int'(bus_if.valid), 0);
    chk("t6_rst_inf",   int'(bus_if.inf),   0);
    issue(XG, YG);
    wait_done(lat);
    chk("t6_first_latency", lat, 21);
    chk("t6_first_valid", int'(bus_if.valid), 1);
    issue(XG, YG ^ 233'd1);
    chk("t6_busy_b2b", int'(bus_if.busy), 1);
    wait_done(lat2);
    chk("t6_gap", (lat2 < 0) ? -1 : lat2 + 1, 22);
    chk("t6_second_valid", int'(bus_if.valid), 0);
    step();
    chk("t6_done_pulse", int'(bus_if.done), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
